// File: rtl/sc_pkg.sv
// Shared types and helpers for the sequential stochastic-computing multiplier.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    UNIPOLAR = 1'b0,
    BIPOLAR  = 1'b1
  } mode_e;

  // Reverses the low w bits of v (1 <= w <= 64); bits above w come back as zero.
  function automatic logic [63:0] bitrev(input logic [63:0] v, input int unsigned w);
    logic [63:0] r;
    r = {<<{v}};
    return r >> (64 - w);
  endfunction

  // Scales an l-bit-stream ones count up to Q0.n; a full stream saturates to all ones.
  function automatic logic [63:0] sat_rescale(input logic [63:0] ones,
                                               input int unsigned n,
                                               input int unsigned l);
    if (ones == (64'd1 << l)) return (64'd1 << n) - 64'd1;
    return ones << (n - l);
  endfunction

endpackage

// File: rtl/sc_sng.sv
// Stochastic number generator: compares a (optionally bit-reversed) counter against a level.
module sc_sng
  import sc_pkg::*;
#(
  parameter int L = 8
) (
  input  logic [L-1:0] k,
  input  logic [L-1:0] q,
  input  logic         rev,
  output logic         s_bit
);

  logic [L-1:0] idx;

  assign idx   = rev ? L'(bitrev(64'(k), L)) : k;
  assign s_bit = (idx < q);

endmodule

// File: rtl/sc_mul_seq.sv
// Sequential stochastic-computing multiplier: 2^L-cycle streams, AND/XNOR combine, count, rescale.
module sc_mul_seq
  import sc_pkg::*;
#(
  parameter int N = 16,
  parameter int L = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bipolar,
  input  logic         clear,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] p,
  output logic         sc_bit
);

  localparam logic [L-1:0] K_LAST = '1;

  state_e       state, state_next;
  mode_e        mode;
  logic [L-1:0] k, qa, qb;
  logic [L-1:0] qa_in, qb_in;
  logic [L:0]   ones, ones_next;
  logic         sa, sb, s;
  logic         accept;

  sc_sng #(.L(L)) u_sng_a (.k(k), .q(qa), .rev(1'b0), .s_bit(sa));
  sc_sng #(.L(L)) u_sng_b (.k(k), .q(qb), .rev(1'b1), .s_bit(sb));

  // Truncate to the top L bits of each operand; no rounding.
  assign qa_in = L'(a >> (N - L));
  assign qb_in = L'(b >> (N - L));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && !clear;

  assign s         = (mode == BIPOLAR) ? ~(sa ^ sb) : (sa & sb);
  assign ones_next = ones + (L+1)'(s);

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (in_valid) state_next = RUN;
        RUN:     if (k == K_LAST) state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k      <= '0;
      ones   <= '0;
      qa     <= '0;
      qb     <= '0;
      mode   <= UNIPOLAR;
      p      <= '0;
      sc_bit <= 1'b0;
    end else if (clear) begin
      // Abort keeps the last published product.
      k    <= '0;
      ones <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            qa   <= qa_in;
            qb   <= qb_in;
            mode <= mode_e'(bipolar);
            k    <= '0;
            ones <= '0;
          end
        end
        RUN: begin
          ones   <= ones_next;
          sc_bit <= s;
          k      <= k + 1'b1;
          if (k == K_LAST) p <= N'(sat_rescale(64'(ones_next), N, L));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_mul_seq.sv
// Scoreboard bench for sc_mul_seq (N=16/L=8 primary instance, plus an N=8/L=8 instance).
module tb_sc_mul_seq;

  localparam int N = 16;
  localparam int L = 8;

  typedef struct {
    logic [15:0] p;
    int          ones;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, bipolar, clear, out_valid, out_ready, sc_bit;
  logic [15:0] a, b, p;

  logic        in_valid8, in_ready8, bipolar8, out_valid8, out_ready8, sc_bit8;
  logic [7:0]  a8, b8, p8;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sc_mul_seq #(.N(N), .L(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bipolar(bipolar), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .p(p), .sc_bit(sc_bit)
  );

  sc_mul_seq #(.N(8), .L(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bipolar(bipolar8), .clear(1'b0), .out_valid(out_valid8),
    .out_ready(out_ready8), .p(p8), .sc_bit(sc_bit8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference stream count, written directly from the stream definitions.
  function automatic int model_ones(input logic [15:0] av, input logic [15:0] bv, input logic bip);
    logic [7:0] qa, qb, kk, rk;
    logic       sa, sb;
    int         cnt;
    qa  = av[15:8];
    qb  = bv[15:8];
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      kk = 8'(k);
      for (int i = 0; i < 8; i++) rk[i] = kk[7-i];
      sa = (kk < qa);
      sb = (rk < qb);
      if (bip ? (sa == sb) : (sa & sb)) cnt++;
    end
    return cnt;
  endfunction

  function automatic logic [15:0] model_p(input int ones);
    if (ones == 256) return 16'hFFFF;
    return 16'(ones << 8);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic bip,
                        input logic [15:0] exp_p, input int exp_ones, input int hold);
    exp_t e;
    int   cyc;
    int   ones_seen;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = av; b = bv; bipolar = bip; in_valid = 1'b1;
    tick();
    e.p = exp_p; e.ones = exp_ones;
    exp_q.push_back(e);
    check("in_ready_run", 32'(in_ready), 32'd0);
    // Scramble operands and pulse handshakes during RUN; none of it may matter.
    a = 16'($urandom); b = 16'($urandom); bipolar = 1'($urandom); out_ready = 1'b1;
    cyc = 0; ones_seen = 0;
    while (!out_valid && cyc < 400) begin
      tick();
      cyc++;
      ones_seen += int'(sc_bit);
      if (cyc == 10) begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
      end
    end
    check("latency", 32'(cyc), 32'd256);
    check("sc_bit_count", 32'(ones_seen), 32'(exp_ones));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_p", 32'(p), 32'(exp_p));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("p", 32'(p), 32'(e.p));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rbip;
    int          ro, cyc;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bipolar = 1'b0; clear = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; bipolar8 = 1'b0; out_ready8 = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    check("rst_sc_bit", 32'(sc_bit), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(16'h0000, 16'hFFFF, 1'b0, 16'h0000, 0,   0);
    run_op(16'hFFFF, 16'h8000, 1'b0, 16'h8000, 128, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h4000, 64,  10);
    run_op(16'h8000, 16'h8000, 1'b1, 16'h8000, 128, 0);
    run_op(16'hFFFF, 16'h8000, 1'b1, 16'h8100, 129, 0);
    run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 256, 2);

    for (int t = 0; t < 6; t++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbip = 1'(t);
      ro = model_ones(ra, rb, rbip);
      run_op(ra, rb, rbip, model_p(ro), ro, 0);
    end

    // Reset in the middle of RUN.
    run_op(16'h8000, 16'h8000, 1'b0, 16'h4000, 64, 0);
    a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_q.delete();
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    tick();
    check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_p", 32'(p), 32'd0);
    rst_n = 1'b1;
    expect_quiet("quiet_after_reset", 300);

    // Clear in the middle of RUN, then a clear colliding with an accept in IDLE.
    run_op(16'hFFFF, 16'h8000, 1'b0, 16'h8000, 128, 0);
    a = 16'h0000; b = 16'h0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    clear = 1'b1; in_valid = 1'b1;
    tick();
    check("clear_in_ready", 32'(in_ready), 32'd1);
    check("clear_out_valid", 32'(out_valid), 32'd0);
    check("clear_p_kept", 32'(p), 32'h8000);
    tick();
    check("clear_drops_accept", 32'(in_ready), 32'd1);
    clear = 1'b0; in_valid = 1'b0;
    expect_quiet("quiet_after_clear", 300);
    run_op(16'hC000, 16'hC000, 1'b0, model_p(model_ones(16'hC000, 16'hC000, 1'b0)),
           model_ones(16'hC000, 16'hC000, 1'b0), 0);

    // N=8, L=8 instance: no truncation, no shift.
    a8 = 8'h80; b8 = 8'h80; bipolar8 = 1'b0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    cyc = 0;
    while (!out_valid8 && cyc < 400) begin
      tick();
      cyc++;
    end
    check("n8_latency", 32'(cyc), 32'd256);
    check("n8_p", 32'(p8), 32'h40);
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check("n8_out_valid_drop", 32'(out_valid8), 32'd0);
    check("n8_in_ready", 32'(in_ready8), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sc_mul_seq.md
Name: sc_mul_seq

Overview:
- Sequential stochastic-computing multiplier, the successor to the combinational fixed-point multiplier.
- Accepts two Q0.N operands and generates two deterministic low-discrepancy bitstreams of length 2^L: a ramp counter for A and a bit-reversed counter for B.
- Combines the streams bitwise (AND for unipolar, XNOR for bipolar) and counts ones.
- Returns the count rescaled to Q0.N.
- Sits beside the exact multiplier as the SC datapath primitive, with valid/ready on both sides.

Parameters:
- N, 16, operand/result width, Q0.N unsigned (offset-binary when bipolar).
- L, 8, log2 stream length; 1 <= L <= N; stream length 2^L cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands/mode valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  N  operand A, Q0.N.
- b  in  N  operand B, Q0.N.
- bipolar  in  1  0 = unipolar AND, 1 = bipolar XNOR; sampled on accept.
- clear  in  1  synchronous abort to IDLE.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- p  out  N  product, Q0.N, stable while out_valid.
- sc_bit  out  1  registered combined stream bit, for debug/observation.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, in_ready=1, out_valid=0, p=0, sc_bit=0, counters=0. Reset overrides everything, including mid-RUN and mid-DONE; any in-flight result is lost.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept on an edge with in_valid&in_ready.
  - Capture qa=a[N-1:N-L] and qb=b[N-1:N-L] (truncation, no rounding). Capture bipolar.
  - Set k=0, ones=0, go to RUN.
- RUN: one stream bit per cycle for k=0..2^L-1.
  - sa=(k<qa).
  - sb=(bitrev_L(k)<qb).
  - s = sa&sb when unipolar, ~(sa^sb) when bipolar.
  - ones+=s, sc_bit<=s, k+=1.
  - ones is L+1 bits wide.
  - On the edge processing k=2^L-1, go to DONE and load p.
- Latency: out_valid rises exactly 2^L cycles after the accept edge.
- Result rule:
  - p = ones << (N-L).
  - If ones==2^L, p saturates to 2^N-1. This is reachable only in bipolar mode.
- DONE:
  - out_valid=1, p held.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE.
  - in_ready remains 0 in DONE; no overlap between result hold and the next accept.
- out_ready outside DONE is ignored.
- in_valid outside IDLE is ignored, with no capture.
- clear=1 (lower priority than reset, higher than everything else): go to IDLE, out_valid=0, ones/k=0. p keeps its last value. An accept in the same cycle is dropped.
- The k counter must not wrap into a second stream; the transition out of RUN is keyed on k==2^L-1.
- Operand changes after accept have no effect.

Decomposition:
- Shared package sc_pkg:
  - state enum {IDLE, RUN, DONE}.
  - bitrev function (width-parametric).
  - Mode encodings UNIPOLAR=0, BIPOLAR=1.
  - Saturating rescale helper.
- Sub-module sc_sng (#(L), inputs k, q, rev; output bit). Computes (rev ? bitrev(k) : k) < q. Instantiated twice, rev=0 for A and rev=1 for B.

Test Plan (N=16, L=8 unless stated):
- a=0x0000, b=0xFFFF, unipolar -> out_valid exactly 256 cycles after accept, p=0x0000.
- a=0xFFFF, b=0x8000, unipolar -> ones=128, p=0x8000.
- a=0x8000, b=0x8000, unipolar -> ones=64, p=0x4000. Hold out_ready=0 for 10 cycles -> p/out_valid stable, in_ready=0.
- Bipolar:
  - a=b=0x8000 -> ones=128, p=0x8000 (value 0).
  - a=0xFFFF, b=0x8000 -> ones=129, p=0x8100.
  - a=b=0x0000 -> ones=256, p=0xFFFF (saturation).
- Back-to-back: accept, drain with out_ready=1, re-accept in the next IDLE cycle. Change a/b during RUN -> result reflects the captured operands only.
- Assert rst_n=0 at RUN cycle 100 -> next cycle in_ready=1, out_valid=0, p=0. clear=1 at RUN cycle 50 -> IDLE, no out_valid. Repeat with N=8, L=8 and a=b=0x80 -> p=0x40.
